// File: rtl/memory_access.sv
// Memory stage: drives the data bus for loads and stores, extracts load data and registers the writeback stage outputs.
// Optional macro MEM_BUS_TIMEOUT_EN abandons a load after BUS_TIMEOUT WAIT cycles and raises o_mem_fault.
module memory_access #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_exec_mem_rd,
  input  logic        i_exec_mem_writeback,
  input  logic        i_exec_mem_mem_w,
  input  logic        i_exec_mem_mem_r,
  input  logic        i_exec_mem_mem_rdu,
  input  logic        i_exec_mem_mem_byte,
  input  logic        i_exec_mem_mem_hwrd,
  input  logic [31:0] i_exec_mem_alu_result,
  input  logic [31:0] i_exec_mem_mem_wdata,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_wstrb,
  input  logic        i_dbus_gnt,
  input  logic        i_dbus_rvalid,
  input  logic [31:0] i_dbus_rdata,
  output logic [5:0]  b_mem_wb_rd,
  output logic        b_mem_wb_writeback,
  output logic [31:0] b_mem_wb_result,
  output logic        o_mem_stall,
  output logic        o_mem_misalign,
  output logic        o_mem_fault
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(BUS_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic           mem_op, is_store, misaligned, rdata_take, timeout_hit, timed_out;
  logic [3:0]     strb;
  logic [31:0]    lane_data, load_data, lane_sel, load_ext;
  logic [CW-1:0]  wait_cnt;

  // Request decode: alignment, byte strobes and lane-replicated store data.
  always_comb begin
    mem_op     = i_exec_mem_mem_w | i_exec_mem_mem_r;
    is_store   = i_exec_mem_mem_w;
    misaligned = 1'b0;
    strb       = 4'b0000;
    lane_data  = i_exec_mem_mem_wdata;
    if (i_exec_mem_mem_byte) begin
      strb      = 4'b0001 << i_exec_mem_alu_result[1:0];
      lane_data = {4{i_exec_mem_mem_wdata[7:0]}};
    end else if (i_exec_mem_mem_hwrd) begin
      misaligned = i_exec_mem_alu_result[0];
      strb       = i_exec_mem_alu_result[1] ? 4'b1100 : 4'b0011;
      lane_data  = {2{i_exec_mem_mem_wdata[15:0]}};
    end else begin
      misaligned = (i_exec_mem_alu_result[1:0] != 2'b00);
      strb       = 4'b1111;
    end
    if (!is_store) begin
      strb = 4'b0000;
    end else begin
      strb = strb;
    end
  end

  // Load data extraction with sign or zero extension.
  always_comb begin
    lane_sel = load_data >> {i_exec_mem_alu_result[1:0], 3'b000};
    load_ext = load_data;
    if (i_exec_mem_mem_byte) begin
      load_ext = i_exec_mem_mem_rdu ? {24'h000000, lane_sel[7:0]}
                                    : {{24{lane_sel[7]}}, lane_sel[7:0]};
    end else if (i_exec_mem_mem_hwrd) begin
      load_ext = i_exec_mem_mem_rdu ? {16'h0000, lane_sel[15:0]}
                                    : {{16{lane_sel[15]}}, lane_sel[15:0]};
    end else begin
      load_ext = load_data;
    end
  end

  assign rdata_take = i_dbus_rvalid &&
                      (((state == REQ) && i_dbus_gnt && !is_store) || (state == WAIT));

`ifdef MEM_BUS_TIMEOUT_EN
  assign timeout_hit = (state == WAIT) && !i_dbus_rvalid && (wait_cnt == TMO_MAX - CW'(1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and the combinational stall.
  always_comb begin
    state_nxt   = state;
    o_mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          o_mem_stall = 1'b1;
          state_nxt   = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        o_mem_stall = 1'b1;
        if (i_dbus_gnt) state_nxt = (is_store || i_dbus_rvalid) ? DONE : WAIT;
        else            state_nxt = REQ;
      end
      WAIT: begin
        o_mem_stall = 1'b1;
        if (i_dbus_rvalid || timeout_hit) state_nxt = DONE;
        else                              state_nxt = WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT cycle counter; saturates so it never wraps when the timeout is disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                             wait_cnt <= '0;
    else if (state != WAIT)                                   wait_cnt <= '0;
    else if (!i_dbus_rvalid && (wait_cnt != TMO_MAX))         wait_cnt <= wait_cnt + CW'(1);
    else                                                      wait_cnt <= wait_cnt;
  end

  // Bus request registers, load capture and writeback stage outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dbus_req         <= 1'b0;
      o_dbus_we          <= 1'b0;
      o_dbus_addr        <= 32'h00000000;
      o_dbus_wdata       <= 32'h00000000;
      o_dbus_wstrb       <= 4'b0000;
      b_mem_wb_rd        <= 6'd0;
      b_mem_wb_writeback <= 1'b0;
      b_mem_wb_result    <= 32'h00000000;
      o_mem_misalign     <= 1'b0;
      o_mem_fault        <= 1'b0;
      load_data          <= 32'h00000000;
      timed_out          <= 1'b0;
    end else begin
      o_mem_misalign <= 1'b0;
      o_mem_fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            b_mem_wb_writeback <= 1'b0;
            if (misaligned) begin
              o_mem_misalign <= 1'b1;
            end else begin
              o_dbus_req   <= 1'b1;
              o_dbus_we    <= is_store;
              o_dbus_addr  <= {i_exec_mem_alu_result[31:2], 2'b00};
              o_dbus_wdata <= lane_data;
              o_dbus_wstrb <= strb;
            end
          end else begin
            b_mem_wb_rd        <= i_exec_mem_rd;
            b_mem_wb_writeback <= i_exec_mem_writeback;
            b_mem_wb_result    <= i_exec_mem_alu_result;
          end
        end
        REQ: begin
          b_mem_wb_writeback <= 1'b0;
          if (i_dbus_gnt) begin
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_wstrb <= 4'b0000;
          end
          if (rdata_take) load_data <= i_dbus_rdata;
        end
        WAIT: begin
          b_mem_wb_writeback <= 1'b0;
          if (rdata_take)       load_data <= i_dbus_rdata;
          else if (timeout_hit) timed_out <= 1'b1;
        end
        DONE: begin
          b_mem_wb_rd        <= i_exec_mem_rd;
          b_mem_wb_writeback <= (is_store || timed_out) ? 1'b0 : i_exec_mem_writeback;
          b_mem_wb_result    <= timed_out ? 32'h00000000
                                          : (is_store ? i_exec_mem_alu_result : load_ext);
          o_mem_fault        <= timed_out;
          timed_out          <= 1'b0;
        end
        default: begin
          o_dbus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomised and directed bench for memory_access against a transaction-level model.
module tb_memory_access;

  localparam int BT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [5:0]  i_exec_mem_rd = 6'd0;
  logic        i_exec_mem_writeback = 1'b0;
  logic        i_exec_mem_mem_w = 1'b0, i_exec_mem_mem_r = 1'b0, i_exec_mem_mem_rdu = 1'b0;
  logic        i_exec_mem_mem_byte = 1'b0, i_exec_mem_mem_hwrd = 1'b0;
  logic [31:0] i_exec_mem_alu_result = 32'h0, i_exec_mem_mem_wdata = 32'h0;
  logic        o_dbus_req, o_dbus_we;
  logic [31:0] o_dbus_addr, o_dbus_wdata;
  logic [3:0]  o_dbus_wstrb;
  logic        i_dbus_gnt = 1'b0, i_dbus_rvalid = 1'b0;
  logic [31:0] i_dbus_rdata = 32'h0;
  logic [5:0]  b_mem_wb_rd;
  logic        b_mem_wb_writeback;
  logic [31:0] b_mem_wb_result;
  logic        o_mem_stall, o_mem_misalign, o_mem_fault;

  memory_access #(.BUS_TIMEOUT(BT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exec_mem_rd(i_exec_mem_rd), .i_exec_mem_writeback(i_exec_mem_writeback),
    .i_exec_mem_mem_w(i_exec_mem_mem_w), .i_exec_mem_mem_r(i_exec_mem_mem_r),
    .i_exec_mem_mem_rdu(i_exec_mem_mem_rdu), .i_exec_mem_mem_byte(i_exec_mem_mem_byte),
    .i_exec_mem_mem_hwrd(i_exec_mem_mem_hwrd), .i_exec_mem_alu_result(i_exec_mem_alu_result),
    .i_exec_mem_mem_wdata(i_exec_mem_mem_wdata),
    .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
    .o_dbus_wdata(o_dbus_wdata), .o_dbus_wstrb(o_dbus_wstrb),
    .i_dbus_gnt(i_dbus_gnt), .i_dbus_rvalid(i_dbus_rvalid), .i_dbus_rdata(i_dbus_rdata),
    .b_mem_wb_rd(b_mem_wb_rd), .b_mem_wb_writeback(b_mem_wb_writeback),
    .b_mem_wb_result(b_mem_wb_result), .o_mem_stall(o_mem_stall),
    .o_mem_misalign(o_mem_misalign), .o_mem_fault(o_mem_fault)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // expectations for the current cycle (e_*) and for the cycle after the next edge (p_*)
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [3:0]  e_wstrb = 4'h0;
  logic        e_wb = 1'b0, e_mis = 1'b0, e_fault = 1'b0;
  logic [5:0]  e_rd = 6'd0;
  logic [31:0] e_res = 32'h0;
  logic        p_wb = 1'b0, p_mis = 1'b0, p_fault = 1'b0;
  logic [5:0]  p_rd = 6'd0;
  logic [31:0] p_res = 32'h0;
  int          stall_cnt = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] rdat, input logic [31:0] a,
                                             input logic rdu, input logic by, input logic hw);
    int sz, off;
    logic [31:0] v, m;
    sz  = by ? 1 : (hw ? 2 : 4);
    off = (sz == 4) ? 0 : int'(a[1:0]);
    v   = rdat >> (8 * off);
    if (sz < 4) begin
      m = (32'h1 << (8 * sz)) - 32'h1;
      v = v & m;
      if (!rdu && v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  // compare process: every cycle, against the model's expectations
  always @(negedge i_clk) begin
    if (o_mem_stall) stall_cnt++;
    if (o_dbus_req) begin
      last_addr  = o_dbus_addr;
      last_wdata = o_dbus_wdata;
      last_wstrb = o_dbus_wstrb;
    end
    if (chk_en) begin
      chk("stall", {31'd0, o_mem_stall}, {31'd0, e_stall});
      chk("req", {31'd0, o_dbus_req}, {31'd0, e_req});
      if (e_req) begin
        chk("addr", o_dbus_addr, e_addr);
        chk("we", {31'd0, o_dbus_we}, {31'd0, e_we});
        if (e_we) begin
          chk("wdata", o_dbus_wdata, e_wdata);
          chk("wstrb", {28'd0, o_dbus_wstrb}, {28'd0, e_wstrb});
        end
      end
      chk("wb", {31'd0, b_mem_wb_writeback}, {31'd0, e_wb});
      if (e_wb) begin
        chk("rd", {26'd0, b_mem_wb_rd}, {26'd0, e_rd});
        chk("result", b_mem_wb_result, e_res);
      end
      chk("misalign", {31'd0, o_mem_misalign}, {31'd0, e_mis});
      chk("fault", {31'd0, o_mem_fault}, {31'd0, e_fault});
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    e_wb = p_wb; e_rd = p_rd; e_res = p_res; e_mis = p_mis; e_fault = p_fault;
    p_wb = 1'b0; p_mis = 1'b0; p_fault = 1'b0;
  endtask

  // g: REQ cycles before gnt; v: WAIT cycles until rvalid (0 = with gnt, <0 = never)
  task automatic run_instr(input logic w, input logic r, input logic rdu, input logic by,
                           input logic hw, input logic [5:0] rd, input logic wb,
                           input logic [31:0] a, input logic [31:0] wd, input int g,
                           input int v, input logic [31:0] rdat);
    logic is_mem, mis, tmo;
    int sz, off;
    i_exec_mem_rd = rd; i_exec_mem_writeback = wb; i_exec_mem_mem_w = w;
    i_exec_mem_mem_r = r; i_exec_mem_mem_rdu = rdu; i_exec_mem_mem_byte = by;
    i_exec_mem_mem_hwrd = hw; i_exec_mem_alu_result = a; i_exec_mem_mem_wdata = wd;
    is_mem = w | r;
    sz  = by ? 1 : (hw ? 2 : 4);
    mis = is_mem && ((a[1:0] & 2'(sz - 1)) != 2'b00);
    off = (sz == 4) ? 0 : int'(a[1:0]);
    tmo = (v < 0);
    e_req = 1'b0;
    if (!is_mem) begin
      e_stall = 1'b0;
      p_wb = wb; p_rd = rd; p_res = a;
      i_dbus_rvalid = 1'($urandom_range(0, 1));
      i_dbus_rdata  = $urandom;
      step();
      i_dbus_rvalid = 1'b0;
    end else if (mis) begin
      e_stall = 1'b0; p_mis = 1'b1;
      step();
    end else begin
      e_stall = 1'b1;
      step();
      e_addr = {a[31:2], 2'b00};
      e_we   = w;
      for (int l = 0; l < 4; l++) begin
        e_wstrb[l] = (l >= off) && (l < off + sz);
        e_wdata[8*l +: 8] = wd[8*(l % sz) +: 8];
      end
      for (int k = 0; k <= g; k++) begin
        e_stall = 1'b1; e_req = 1'b1;
        i_dbus_gnt = (k == g);
        if (k == g && !w && v == 0) begin
          i_dbus_rvalid = 1'b1; i_dbus_rdata = rdat;
        end
        step();
        i_dbus_gnt = 1'b0; i_dbus_rvalid = 1'b0;
      end
      e_req = 1'b0;
      if (!w) begin
        for (int j = 1; j <= (tmo ? BT : v); j++) begin
          e_stall = 1'b1;
          i_dbus_rvalid = !tmo && (j == v);
          i_dbus_rdata  = i_dbus_rvalid ? rdat : $urandom;
          step();
          i_dbus_rvalid = 1'b0;
        end
      end
      e_stall = 1'b0;
      p_wb  = (w || tmo) ? 1'b0 : wb;
      p_rd  = rd;
      p_res = tmo ? 32'h0 : load_model(rdat, a, rdu, by, hw);
      p_fault = tmo;
      step();
    end
  endtask

  task automatic clear_inputs();
    i_exec_mem_rd = 6'd0; i_exec_mem_writeback = 1'b0; i_exec_mem_mem_w = 1'b0;
    i_exec_mem_mem_r = 1'b0; i_exec_mem_mem_rdu = 1'b0; i_exec_mem_mem_byte = 1'b0;
    i_exec_mem_mem_hwrd = 1'b0; i_exec_mem_alu_result = 32'h0; i_exec_mem_mem_wdata = 32'h0;
    i_dbus_gnt = 1'b0; i_dbus_rvalid = 1'b0;
  endtask

  task automatic zero_model();
    e_stall = 1'b0; e_req = 1'b0; e_wb = 1'b0; e_mis = 1'b0; e_fault = 1'b0;
    p_wb = 1'b0; p_mis = 1'b0; p_fault = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, o_dbus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, o_dbus_we}, 32'd0);
    chk({tag, "_addr"}, o_dbus_addr, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, o_dbus_wstrb}, 32'd0);
    chk({tag, "_wb"}, {31'd0, b_mem_wb_writeback}, 32'd0);
    chk({tag, "_result"}, b_mem_wb_result, 32'd0);
    chk({tag, "_stall"}, {31'd0, o_mem_stall}, 32'd0);
    chk({tag, "_fault"}, {31'd0, o_mem_fault}, 32'd0);
  endtask

  initial begin
    logic w, r, by, hw;
    int kind, s;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    zero_model();
    chk_en = 1'b1;

    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1, 32'h1234, 32'h0, 0, 0, 32'h0);
    chk("alu_rd", {26'd0, b_mem_wb_rd}, 32'd5);
    chk("alu_result", b_mem_wb_result, 32'h1234);
    chk("alu_wb", {31'd0, b_mem_wb_writeback}, 32'd1);

    stall_cnt = 0;
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b1, 32'h103, 32'hAB, 0, 0, 32'h0);
    chk("sb_addr", last_addr, 32'h100);
    chk("sb_wstrb", {28'd0, last_wstrb}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    chk("sb_stalls", stall_cnt, 32'd2);
    chk("sb_wb", {31'd0, b_mem_wb_writeback}, 32'd0);

    stall_cnt = 0;
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, 32'h22, 32'h0, 0, 0, 32'h80010000);
    chk("lh_result", b_mem_wb_result, 32'hFFFF8001);
    chk("lh_stalls", stall_cnt, 32'd2);
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 32'h22, 32'h0, 0, 0, 32'h80010000);
    chk("lhu_result", b_mem_wb_result, 32'h00008001);

    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h41, 32'h0, 0, 0, 32'h0);
    chk("mis_pulse", {31'd0, o_mem_misalign}, 32'd1);
    chk("mis_req", {31'd0, o_dbus_req}, 32'd0);
    chk("mis_wb", {31'd0, b_mem_wb_writeback}, 32'd0);

`ifdef MEM_BUS_TIMEOUT_EN
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 1'b1, 32'h200, 32'h0, 0, -1, 32'h0);
    chk("tmo_fault", {31'd0, o_mem_fault}, 32'd1);
    chk("tmo_wb", {31'd0, b_mem_wb_writeback}, 32'd0);
`else
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 1'b1, 32'h200, 32'h0, 1, 6, 32'h12345678);
    chk("slow_result", b_mem_wb_result, 32'h12345678);
    chk("slow_fault", {31'd0, o_mem_fault}, 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      w = (kind == 1);
      r = (kind == 2) || (w && ($urandom_range(0, 3) == 0));
      s = $urandom_range(0, 2);
      by = (s == 0);
      hw = (s == 1);
      run_instr(w, r, 1'($urandom), by, hw, 6'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // reset while a load waits for data
    chk_en = 1'b0;
    clear_inputs();
    i_exec_mem_mem_r = 1'b1; i_exec_mem_writeback = 1'b1; i_exec_mem_rd = 6'd3;
    i_exec_mem_alu_result = 32'h80;
    step();
    i_dbus_gnt = 1'b1;
    step();
    i_dbus_gnt = 1'b0;
    step();
    #2;
    i_rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_all_zero("rst_wait");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_dbus_rvalid = 1'b1;
    i_dbus_rdata = 32'hDEADBEEF;
    step();
    i_dbus_rvalid = 1'b0;
    chk_all_zero("late_rvalid");
    zero_model();
    chk_en = 1'b1;
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 1'b1, 32'hCAFE0001, 32'h0, 0, 0, 32'h0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge i_clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
